// File: rtl/fetch_issue_splitter.sv
// Splits one 64-bit fetch_fifo entry into two 32-bit instructions and issues them
// one per cycle to decode over a registered valid/ready handshake.
module fetch_issue_splitter #(
    parameter int unsigned INSN_W = 32,
    parameter int unsigned PC_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              fifo_valid_i,
    input  logic [INSN_W-1:0] fifo_data0_i,
    input  logic [INSN_W-1:0] fifo_data1_i,
    input  logic [PC_W-1:0]   fifo_pc0_i,
    output logic              fifo_pop_o,
    output logic              dec_valid_o,
    output logic [INSN_W-1:0] dec_instr_o,
    output logic [PC_W-1:0]   dec_pc_o,
    input  logic              dec_ready_i
);

    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_e;

    half_e half_q;
    logic  sel;
    logic  can_load;

    // An entry whose pc points at the upper word starts directly at data1.
    assign sel      = (half_q == HALF_HI) | fifo_pc0_i[2];
    assign can_load = fifo_valid_i & (~dec_valid_o | dec_ready_i) & ~flush_i;

    // Pop is gated by reset because dec_valid_o is forced low while in reset.
    assign fifo_pop_o = can_load & sel & rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            half_q      <= HALF_LO;
            dec_valid_o <= 1'b0;
            dec_instr_o <= '0;
            dec_pc_o    <= '0;
        end else if (flush_i) begin
            half_q      <= HALF_LO;
            dec_valid_o <= 1'b0;
        end else if (can_load) begin
            dec_valid_o <= 1'b1;
            dec_instr_o <= sel ? fifo_data1_i : fifo_data0_i;
            dec_pc_o    <= {fifo_pc0_i[PC_W-1:3], sel, 2'b00};
            half_q      <= sel ? HALF_LO : HALF_HI;
        end else if (dec_valid_o && dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_issue_splitter.sv
// Scoreboard bench for fetch_issue_splitter: a queue-based fetch_fifo model feeds the DUT,
// expected issues are queued per entry and a negedge monitor checks every accepted issue.
module tb_fetch_issue_splitter;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned PC_W   = 32;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic              fifo_valid_i;
    logic [INSN_W-1:0] fifo_data0_i;
    logic [INSN_W-1:0] fifo_data1_i;
    logic [PC_W-1:0]   fifo_pc0_i;
    logic              fifo_pop_o;
    logic              dec_valid_o;
    logic [INSN_W-1:0] dec_instr_o;
    logic [PC_W-1:0]   dec_pc_o;
    logic              dec_ready_i;

    fetch_issue_splitter #(.INSN_W(INSN_W), .PC_W(PC_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .fifo_valid_i(fifo_valid_i),
        .fifo_data0_i(fifo_data0_i),
        .fifo_data1_i(fifo_data1_i),
        .fifo_pc0_i  (fifo_pc0_i),
        .fifo_pop_o  (fifo_pop_o),
        .dec_valid_o (dec_valid_o),
        .dec_instr_o (dec_instr_o),
        .dec_pc_o    (dec_pc_o),
        .dec_ready_i (dec_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] pc;
    } entry_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } iss_t;

    entry_t fq[$];
    iss_t   exp_q[$];
    iss_t   mon_e;
    iss_t   held;
    bit     hold_v   = 1'b0;
    bit     pop_flag = 1'b0;
    bit     fifo_gate;
    int     pops     = 0;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: aligned entry yields d0@base then d1@base+4; upper-word entry yields d1 only.
    function automatic void push_exp(input entry_t e);
        logic [31:0] base;
        iss_t        i;
        base = {e.pc[31:3], 3'b000};
        if (!e.pc[2]) begin
            i.instr = e.d0;
            i.pc    = base;
            exp_q.push_back(i);
        end
        i.instr = e.d1;
        i.pc    = base + 32'd4;
        exp_q.push_back(i);
    endfunction

    task automatic drive_fifo();
        fifo_valid_i = fifo_gate && (fq.size() > 0);
        if (fq.size() > 0) begin
            fifo_data0_i = fq[0].d0;
            fifo_data1_i = fq[0].d1;
            fifo_pc0_i   = fq[0].pc;
        end else begin
            fifo_data0_i = '0;
            fifo_data1_i = '0;
            fifo_pc0_i   = '0;
        end
    endtask

    task automatic add_entry(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] pc);
        entry_t e;
        e.d0 = d0;
        e.d1 = d1;
        e.pc = pc;
        fq.push_back(e);
        push_exp(e);
        drive_fifo();
    endtask

    task automatic rebuild_exp();
        exp_q.delete();
        foreach (fq[k]) push_exp(fq[k]);
    endtask

    task automatic step();
        entry_t tmp;
        @(posedge clk);
        #1;
        if (pop_flag) begin
            if (fq.size() > 0) tmp = fq.pop_front();
            pop_flag = 1'b0;
        end
        if (flush_i) begin
            fq.delete();
            exp_q.delete();
            flush_i = 1'b0;
        end
        drive_fifo();
    endtask

    task automatic drain();
        dec_ready_i = 1'b1;
        fifo_gate   = 1'b1;
        flush_i     = 1'b0;
        drive_fifo();
        for (int i = 0; i < 40; i++) begin
            if (fq.size() == 0 && exp_q.size() == 0 && !dec_valid_o) break;
            step();
        end
        check("drain_exp_empty", exp_q.size(), 0);
        check("drain_fifo_empty", fq.size(), 0);
    endtask

    // Monitor: inputs only change just after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (!rst_ni) begin
            hold_v = 1'b0;
            check("pop_in_reset", fifo_pop_o, 0);
        end else begin
            if (flush_i) check("pop_during_flush", fifo_pop_o, 0);
            if (fifo_pop_o) begin
                pops++;
                pop_flag = 1'b1;
                check("pop_needs_valid", fifo_valid_i, 1);
            end
            if (hold_v && dec_valid_o) begin
                check("stall_instr_stable", dec_instr_o, held.instr);
                check("stall_pc_stable", dec_pc_o, held.pc);
            end
            if (dec_valid_o && dec_ready_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_issue: got 0x%08h@0x%08h expected no issue at %0t",
                             dec_instr_o, dec_pc_o, $time);
                end else begin
                    n_checks--;
                    mon_e = exp_q.pop_front();
                    check("issue_instr", dec_instr_o, mon_e.instr);
                    check("issue_pc", dec_pc_o, mon_e.pc);
                end
            end
            hold_v     = dec_valid_o && !dec_ready_i;
            held.instr = dec_instr_o;
            held.pc    = dec_pc_o;
        end
    end

    int p0;

    initial begin
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        dec_ready_i = 1'b1;
        fifo_gate   = 1'b1;
        drive_fifo();
        // Upper-word entry visible during reset: pop must stay low until release.
        add_entry(32'hCCCC0001, 32'hDDDD0002, 32'h0000_2004);
        #2;
        check("reset_valid", dec_valid_o, 0);
        check("reset_instr", dec_instr_o, 0);
        check("reset_pc", dec_pc_o, 0);
        check("reset_pop", fifo_pop_o, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Misaligned single issue, then aligned entry proves half stayed at data0.
        p0 = pops;
        step();
        check("t2_latency_valid", dec_valid_o, 1);
        check("t2_pc", dec_pc_o, 32'h0000_2004);
        add_entry(32'hAAAA0001, 32'hBBBB0002, 32'h0000_1000);
        step();
        check("t1_d0_instr", dec_instr_o, 32'hAAAA0001);
        step();
        check("t1_d1_pc", dec_pc_o, 32'h0000_1004);
        check("t12_pops", pops - p0, 2);

        // Stall on d0 for three cycles.
        add_entry(32'hAAAA0001, 32'hBBBB0002, 32'h0000_1000);
        step();
        dec_ready_i = 1'b0;
        p0 = pops;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_instr", dec_instr_o, 32'hAAAA0001);
            check("t3_no_pop", fifo_pop_o, 0);
        end
        dec_ready_i = 1'b1;
        step();
        check("t3_resume_pc", dec_pc_o, 32'h0000_1004);
        check("t3_pop_count", pops - p0, 1);

        // Flush while half-consumed.
        add_entry(32'hAAAA0001, 32'hBBBB0002, 32'h0000_1000);
        step();
        dec_ready_i = 1'b0;
        flush_i     = 1'b1;
        step();
        check("t4_flush_valid", dec_valid_o, 0);
        dec_ready_i = 1'b1;
        add_entry(32'h11110003, 32'h22220004, 32'h0000_3000);
        step();
        check("t4_new_pc", dec_pc_o, 32'h0000_3000);
        check("t4_new_instr", dec_instr_o, 32'h11110003);
        drain();

        // Streaming: 8 issues, no bubbles, exactly 4 pops.
        p0 = pops;
        for (int i = 0; i < 4; i++)
            add_entry(32'h5000_0000 + i * 2, 32'h5000_0001 + i * 2, i * 8);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t6_no_bubble", dec_valid_o, 1);
        end
        check("t6_pop_count", pops - p0, 4);
        step();
        check("t6_empty_drop", dec_valid_o, 0);
        drain();

        // Asynchronous reset mid-stall; entry must restart at data0 afterwards.
        add_entry(32'h77770001, 32'h88880002, 32'h0000_4000);
        dec_ready_i = 1'b0;
        step();
        step();
        check("t5_pre_valid", dec_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t5_valid", dec_valid_o, 0);
        check("t5_instr", dec_instr_o, 0);
        check("t5_pc", dec_pc_o, 0);
        check("t5_pop", fifo_pop_o, 0);
        @(posedge clk);
        #1;
        rst_ni   = 1'b1;
        pop_flag = 1'b0;
        rebuild_exp();
        drain();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if (fq.size() < 3 && $urandom_range(0, 2) == 0)
                add_entry($urandom, $urandom, $urandom);
            dec_ready_i = ($urandom_range(0, 3) != 0);
            fifo_gate   = ($urandom_range(0, 4) != 0);
            flush_i     = ($urandom_range(0, 40) == 0);
            drive_fifo();
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
